// File: rtl/sys_pkg.sv
// Shared constants and state encoding for the result-tile deskew path.
//   DIM_DEF    : default systolic array dimension
//   BITS_C_DEF : default result element (accumulator) width
package sys_pkg;

  localparam int unsigned DIM_DEF    = 8;
  localparam int unsigned BITS_C_DEF = 64;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} deskew_state_t;

endpackage

// File: rtl/result_row_store.sv
// DIM x DIM result tile storage with per-element write enables and one
// combinational row read port.
//   clk       : clock
//   i_we      : i_we[r][c] writes i_wdata[c] into element (r, c)
//   i_wdata   : one element per column
//   i_raddr   : row to read
//   o_rdata_c : combinational read of row i_raddr, o_rdata_c[c] = element (i_raddr, c)
module result_row_store import sys_pkg::*; #(
  parameter int unsigned DIM    = DIM_DEF,
  parameter int unsigned BITS_C = BITS_C_DEF
) (
  input  logic                           clk,
  input  logic [DIM-1:0][DIM-1:0]        i_we,
  input  logic [DIM-1:0][BITS_C-1:0]     i_wdata,
  input  logic [$clog2(DIM)-1:0]         i_raddr,
  output logic [DIM-1:0][BITS_C-1:0]     o_rdata_c
);

  // Tile contents are fully rewritten on every capture, so no reset is needed.
  logic [DIM-1:0][BITS_C-1:0] r_mem [DIM];

  always_ff @(posedge clk) begin
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        if (i_we[r][c]) r_mem[r][c] <= i_wdata[c];
      end
    end
  end

  assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/memc_deskew.sv
// Re-aligns one skewed DIM x DIM result tile leaving the systolic array into
// rows and drains them over a valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin tile capture (honoured only when idle)
//   en         : array advance strobe; one capture step per en cycle
//   Cin        : Cin[c] = current output of array column c
//   busy       : capture or drain in progress
//   row_valid  : row_data/row_idx hold an aligned row
//   row_ready  : consumer accepts the row
//   row_idx    : index of the row on row_data
//   row_data   : row_data[c] = C[row_idx][c]
//   done       : one-cycle pulse after the last row is accepted
module memc_deskew import sys_pkg::*; #(
  parameter int unsigned BITS_C = BITS_C_DEF,
  parameter int unsigned DIM    = DIM_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        en,
  input  logic [DIM-1:0][BITS_C-1:0]  Cin,
  output logic                        busy,
  output logic                        row_valid,
  input  logic                        row_ready,
  output logic [$clog2(DIM)-1:0]      row_idx,
  output logic [DIM-1:0][BITS_C-1:0]  row_data,
  output logic                        done
);

  localparam int unsigned STEP_W = $clog2(2*DIM-1);
  localparam int unsigned IDX_W  = $clog2(DIM);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2*DIM-2);
  localparam logic [IDX_W-1:0]  LAST_ROW  = IDX_W'(DIM-1);

  deskew_state_t           r_state, w_state_nxt;
  logic [STEP_W-1:0]       r_step,  w_step_nxt;
  logic [IDX_W-1:0]        r_row_idx, w_row_idx_nxt;
  logic                    r_done,  w_done_nxt;
  logic [DIM-1:0][DIM-1:0] w_we;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_step    <= '0;
      r_row_idx <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_step    <= w_step_nxt;
      r_row_idx <= w_row_idx_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Next-state, counters and done.
  always_comb begin
    w_state_nxt   = r_state;
    w_step_nxt    = r_step;
    w_row_idx_nxt = r_row_idx;
    w_done_nxt    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CAPTURE;
          w_step_nxt  = '0;
        end
      end
      S_CAPTURE: begin
        if (en) begin
          if (r_step == LAST_STEP) begin
            w_state_nxt = S_DRAIN;
            w_step_nxt  = '0;
          end else begin
            w_step_nxt  = r_step + STEP_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (row_ready) begin
          if (r_row_idx == LAST_ROW) begin
            w_row_idx_nxt = '0;
            w_state_nxt   = S_IDLE;
            w_done_nxt    = 1'b1;
          end else begin
            w_row_idx_nxt = r_row_idx + IDX_W'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Column c at step s carries element of row s-c; write it when that row exists.
  always_comb begin
    w_we = '0;
    if (r_state == S_CAPTURE && en) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          if (r_step == STEP_W'(r + c)) w_we[r][c] = 1'b1;
        end
      end
    end
  end

  result_row_store #(.DIM(DIM), .BITS_C(BITS_C)) u_store (
    .clk       (clk),
    .i_we      (w_we),
    .i_wdata   (Cin),
    .i_raddr   (r_row_idx),
    .o_rdata_c (row_data)
  );

  assign busy      = (r_state != S_IDLE);
  assign row_valid = (r_state == S_DRAIN);
  assign row_idx   = r_row_idx;
  assign done      = r_done;

endmodule

// File: tb/tb_memc_deskew.sv
// Directed self-checking bench for memc_deskew at DIM=4, BITS_C=16.
module tb_memc_deskew;

  localparam int unsigned DIM    = 4;
  localparam int unsigned BITS_C = 16;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       start = 1'b0;
  logic                       en = 1'b0;
  logic [DIM-1:0][BITS_C-1:0] Cin = '0;
  logic                       busy;
  logic                       row_valid;
  logic                       row_ready = 1'b0;
  logic [1:0]                 row_idx;
  logic [DIM-1:0][BITS_C-1:0] row_data;
  logic                       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  idx;
    logic [63:0] data;
  } row_t;
  row_t sb[$];

  memc_deskew #(.BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .en        (en),
    .Cin       (Cin),
    .busy      (busy),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_idx   (row_idx),
    .row_data  (row_data),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] elem(input logic [15:0] base, input int r, input int c);
    return base + 16'(r * 16 + c);
  endfunction

  // Push the expected aligned rows of a tile onto the scoreboard.
  task automatic push_tile(input logic [15:0] base);
    row_t e;
    for (int r = 0; r < DIM; r++) begin
      e.idx  = 2'(r);
      e.data = '0;
      for (int c = 0; c < DIM; c++) e.data[c*16 +: 16] = elem(base, r, c);
      sb.push_back(e);
    end
  endtask

  // Drive the skewed tile; starts/ends at a negedge.
  task automatic capture(input bit do_start, input bit gaps, input bit start_mid,
                         input logic [15:0] base);
    if (do_start) begin
      start = 1'b1;
      en    = 1'b1;
      Cin   = {$urandom(), $urandom()};
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 64'(busy), 64'd1);
    end
    push_tile(base);
    for (int s = 0; s < 2*DIM-1; s++) begin
      if (gaps) begin
        en  = 1'b0;
        Cin = {$urandom(), $urandom()};
        @(negedge clk);
        check("no_valid_in_gap", 64'(row_valid), 64'd0);
      end
      en = 1'b1;
      for (int c = 0; c < DIM; c++) begin
        int r;
        r = s - c;
        Cin[c] = (r >= 0 && r < DIM) ? elem(base, r, c) : 16'h0;
      end
      start = (start_mid && s == 3);
      if (s == 2*DIM-2) check("no_valid_before_last_en", 64'(row_valid), 64'd0);
      @(negedge clk);
      start = 1'b0;
    end
    en  = 1'b0;
    Cin = {$urandom(), $urandom()};
  endtask

  // Drain one tile against the scoreboard; optional stall, start in drain, start in done cycle.
  task automatic drain(input int stall_row, input int stall_cycles,
                       input bit start_drain, input bit start_done);
    row_t e;
    int   wait_n;
    wait_n = 0;
    while (!row_valid && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    check("row_valid_timeout", 64'(row_valid), 64'd1);
    for (int k = 0; k < DIM; k++) begin
      if (sb.size() == 0) begin
        check("scoreboard_empty", 64'(sb.size()), 64'd1);
        break;
      end
      e = sb.pop_front();
      if (k == stall_row) begin
        row_ready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          check("stall_valid", 64'(row_valid), 64'd1);
          check("stall_idx", 64'(row_idx), 64'(e.idx));
          check("stall_data", 64'(row_data), e.data);
          @(negedge clk);
        end
      end
      row_ready = 1'b1;
      check("row_valid", 64'(row_valid), 64'd1);
      check("row_idx", 64'(row_idx), 64'(e.idx));
      check("row_data", 64'(row_data), e.data);
      check("no_early_done", 64'(done), 64'd0);
      if (start_drain && k == 1) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    row_ready = 1'b0;
    check("done_pulse", 64'(done), 64'd1);
    check("idle_at_done", 64'(busy), 64'd0);
    check("idx_wrapped", 64'(row_idx), 64'd0);
    if (start_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", 64'(done), 64'd0);
    check("busy_after_done", 64'(busy), 64'(start_done));
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(row_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_idx", 64'(row_idx), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    // Aligned tile, no gaps, no backpressure.
    capture(1'b1, 1'b0, 1'b0, 16'h0000);
    drain(-1, 0, 1'b0, 1'b0);

    // en gaps on alternating cycles.
    capture(1'b1, 1'b1, 1'b0, 16'h0000);
    drain(-1, 0, 1'b0, 1'b0);

    // Backpressure on row 2, start while in CAPTURE and in DRAIN.
    capture(1'b1, 1'b0, 1'b1, 16'h1100);
    check("busy_still_capture_path", 64'(busy), 64'd1);
    drain(2, 3, 1'b1, 1'b0);
    check("no_restart_after_drain_start", 64'(busy), 64'd0);

    // Back-to-back: start in the done cycle.
    capture(1'b1, 1'b0, 1'b0, 16'h2200);
    drain(-1, 0, 1'b0, 1'b1);
    capture(1'b0, 1'b0, 1'b0, 16'h3300);
    drain(1, 2, 1'b0, 1'b0);

    // Asynchronous reset mid-capture aborts the tile.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    en    = 1'b1;
    Cin   = {$urandom(), $urandom()};
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_valid", 64'(row_valid), 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post_rst_no_done", 64'(done), 64'd0);
      check("post_rst_idle", 64'(busy), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
